// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit with HI/LO result registers (MIPS mult/div).
// It performs one Booth multiply step or one restoring-divide step per clock.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

    state_t                     state, state_nxt;
    logic [CW-1:0]              cnt;
    logic                       dz;
    logic                       launch;
    logic                       last;

    logic signed [WIDTH:0]      mcand;
    logic signed [2*WIDTH+1:0]  prod, prod_nxt;
    logic signed [WIDTH:0]      booth_sum;

    logic [WIDTH-1:0]           dvs, rem, quo, rem_nxt, quo_nxt, shifted;
    logic [WIDTH:0]             trial;
    logic                       fits;
    logic                       q_neg, r_neg;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign busy     = (state == MULT) || (state == DIV);
    assign done     = (state == FINISH);
    assign div_zero = done && dz;
    assign launch   = start && !busy;
    assign last     = (cnt == CW'(1));

    // Booth step: the upper partial product carries one guard bit so that
    // subtracting the most negative multiplicand cannot overflow.
    always_comb begin
        booth_sum = $signed(prod[2*WIDTH+1:WIDTH+1]);
        case (prod[1:0])
            2'b01:   booth_sum = $signed(prod[2*WIDTH+1:WIDTH+1]) + mcand;
            2'b10:   booth_sum = $signed(prod[2*WIDTH+1:WIDTH+1]) - mcand;
            default: booth_sum = $signed(prod[2*WIDTH+1:WIDTH+1]);
        endcase
        prod_nxt = $signed({booth_sum, prod[WIDTH:0]}) >>> 1;
    end

    always_comb begin
        trial   = {rem, quo[WIDTH-1]};
        shifted = {rem[WIDTH-2:0], quo[WIDTH-1]};
        fits    = trial >= {1'b0, dvs};
        rem_nxt = fits ? (shifted - dvs) : shifted;
        quo_nxt = {quo[WIDTH-2:0], fits};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FINISH: begin
                if (start) state_nxt = op ? ((b == '0) ? FINISH : DIV) : MULT;
                else       state_nxt = IDLE;
            end
            MULT:    if (last) state_nxt = FINISH;
            DIV:     if (last) state_nxt = FINISH;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            dz    <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                cnt <= CW'(WIDTH);
                dz  <= op && (b == '0);
            end else if (busy) begin
                cnt <= cnt - 1'b1;
            end
            if (state == MULT && last) begin
                {hi, lo} <= prod_nxt[2*WIDTH:1];
            end else if (state == DIV && last) begin
                lo <= apply_sign(quo_nxt, q_neg);
                hi <= apply_sign(rem_nxt, r_neg);
            end
        end
    end

    // Operand/working registers need no reset: results reach hi/lo only via the gated writes above.
    always_ff @(posedge clock) begin
        if (launch) begin
            mcand <= $signed({a[WIDTH-1], a});
            prod  <= {{(WIDTH + 1){1'b0}}, b, 1'b0};
            dvs   <= magnitude(b);
            rem   <= '0;
            quo   <= magnitude(a);
            q_neg <= a[WIDTH-1] ^ b[WIDTH-1];
            r_neg <= a[WIDTH-1];
        end else if (state == MULT) begin
            prod  <= prod_nxt;
        end else if (state == DIV) begin
            rem   <= rem_nxt;
            quo   <= quo_nxt;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: the driver queues expected results, and a monitor
// checks them against the results the unit returns when done is high.
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset, start, op;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          n;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no result pending", cyc);
            end else begin
                e = sb.pop_front();
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("div_zero", {31'b0, div_zero}, {31'b0, e.dz});
                chk("latency", 32'(cyc - e.n), 32'(e.lat));
            end
        end
    end

    // Called at a negedge; start is presented for exactly one cycle.
    task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input logic ed,
                         input int lat, input bit expect_result);
        exp_t e;
        start = 1'b1; op = o; a = x; b = y;
        if (expect_result) begin
            e.hi = eh; e.lo = el; e.dz = ed; e.n = cyc + 1; e.lat = lat;
            sb.push_back(e);
        end
        @(negedge clock);
        start = 1'b0; op = 1'b0; a = '0; b = '0;
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (!done && k < 100) begin
            @(negedge clock);
            k++;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got no done after %0d cycles expected done", nm, k);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt;
        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clock);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_div_zero", {31'b0, div_zero}, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // 7 * -3 with busy/done timing
        issue(1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 32, 1'b1);
        busy_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            if (done) break;
            if (busy) busy_cnt++;
            @(negedge clock);
        end
        chk("busy_cycles", 32'(busy_cnt), 32'd32);
        chk("busy_in_finish", {31'b0, busy}, 32'h0);
        @(negedge clock);
        chk("done_one_cycle", {31'b0, done}, 32'h0);

        issue(1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 32, 1'b1);
        wait_done("mult_max");
        @(negedge clock);
        issue(1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 32, 1'b1);
        wait_done("mult_min");
        @(negedge clock);

        issue(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32, 1'b1);
        wait_done("div_neg_dividend");
        @(negedge clock);
        issue(1'b1, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 32, 1'b1);
        wait_done("div_neg_divisor");
        @(negedge clock);

        // 5 / 2 leaves hi=1, lo=2; divide by zero must keep them
        issue(1'b1, 32'd5, 32'd2, 32'h00000001, 32'h00000002, 1'b0, 32, 1'b1);
        wait_done("div_5_2");
        @(negedge clock);
        issue(1'b1, 32'd5, 32'd0, 32'h00000001, 32'h00000002, 1'b1, 0, 1'b1);
        wait_done("div_zero");
        @(negedge clock);
        chk("div_zero_cleared", {31'b0, div_zero}, 32'h0);

        // Overflow divide, then a start accepted during FINISH
        issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 32, 1'b1);
        wait_done("div_overflow");
        issue(1'b0, 32'd3, 32'd4, 32'h00000000, 32'd12, 1'b0, 32, 1'b1);
        wait_done("mult_back_to_back");
        @(negedge clock);

        // New start while busy must be ignored
        issue(1'b0, 32'd100, 32'd200, 32'h00000000, 32'd20000, 1'b0, 32, 1'b1);
        repeat (4) @(negedge clock);
        issue(1'b0, 32'd9, 32'd9, 32'h0, 32'h0, 1'b0, 0, 1'b0);
        wait_done("mult_ignore_start");
        @(negedge clock);

        // Reset mid-operation aborts without a result
        issue(1'b0, 32'd5, 32'd6, 32'h0, 32'h0, 1'b0, 0, 1'b0);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_done", {31'b0, done}, 32'h0);
        repeat (40) @(negedge clock);
        issue(1'b0, 32'd2, 32'd2, 32'h00000000, 32'd4, 1'b0, 32, 1'b1);
        wait_done("mult_after_abort");
        repeat (3) @(negedge clock);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised iterative signed multiply/divide unit for the multicycle CPU datapath; implements MIPS mult/div semantics with HI/LO result registers.
- Sits beside the ALU. The control unit pulses start with operands taken from registers A/B, waits for done, then moves hi/lo into the register file (mfhi/mflo).
- One iteration per clock, so the control FSM must hold its wait state while busy is high.

Parameters:
- WIDTH, 32, operand width in bits; hi/lo are WIDTH each; product is 2*WIDTH. Must be at least 4 and even.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch request; sampled only when busy=0.
- op  input  1  0 = signed multiply, 1 = signed divide; captured with start.
- a  input  WIDTH  multiplicand / dividend, two's complement; captured with start.
- b  input  WIDTH  multiplier / divisor, two's complement; captured with start.
- hi  output  WIDTH  mult: product[2W-1:W]; div: remainder.
- lo  output  WIDTH  mult: product[W-1:0]; div: quotient.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; hi/lo valid from this cycle on.
- div_zero  output  1  pulses with done when a divide had b=0.

Behaviour:
- Reset (synchronous, active-high):
  - hi=0, lo=0, busy=0, done=0, div_zero=0; FSM goes to IDLE; iteration counter cleared.
  - Reset asserted during an operation aborts it; no partial result is ever written to hi/lo.
- FSM states: IDLE, MULT, DIV, FINISH.
- Start acceptance:
  - start=1 and busy=0 at edge N: latch op, a, b; go to MULT or DIV; counter=WIDTH; busy=1 from edge N.
  - Exception: op=1 and b=0 at edge N goes to FINISH instead.
  - start while busy=1 is ignored; latched operands do not change.
- MULT: one iteration per edge (radix-2 Booth or shift-add with sign correction); counter decrements each edge; at counter==1 the next edge goes to FINISH.
- DIV:
  - Restore/non-restore on operand magnitudes, one quotient bit per edge.
  - Signs are fixed up at the final edge: quotient truncated toward zero; remainder takes the sign of the dividend.
- FINISH (one cycle): hi/lo are written at the edge entering FINISH; done=1 and busy=0 during FINISH; the next edge returns to IDLE.
- Latency: start edge N, result edge N+WIDTH. Divide-by-zero: done at edge N+1.
  - done is asserted only for the cycle after the result edge; it is never held.
- Back-to-back: start=1 during the FINISH cycle is accepted, since busy=0 there.
- Divide by zero: hi/lo keep their previous values; div_zero=1 in the same cycle as done, otherwise 0.
- Overflow case a=-2^(W-1), b=-1: lo=-2^(W-1) (two's-complement wrap), hi=0, div_zero=0.
- Multiply never overflows; the full 2W product is always exact.
- hi/lo hold their values between operations and change only at a result edge or on reset.
- Arithmetic internals are sized 2*WIDTH+1 as needed; no truncation before the final result.

Test Plan:
- WIDTH=32, mult a=7, b=-3 (0xFFFFFFFD) -> at edge N+32: hi=0xFFFFFFFF, lo=0xFFFFFFEB; done high exactly one cycle; busy high for the 32 cycles before.
- mult a=0x7FFFFFFF, b=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001. Then mult a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- div a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then div a=7, b=-2 -> lo=0xFFFFFFFD, hi=0x00000001.
- Prior result hi=0x1, lo=0x2; div a=5, b=0 -> done and div_zero at edge N+1; hi=0x1, lo=0x2 unchanged.
- div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0. Then start pulsed during FINISH with mult 3*4 -> accepted; lo=12 at edge 32 later.
- Start mult, pulse start with new operands at cycle 5 -> ignored, original result returned. Start another mult, assert reset at cycle 10 -> hi=lo=0, busy=0, done never pulses; the next mult 2*2 completes normally with lo=4.
